// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 1 << AW;

  // Requester indices into the grant vector
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LD  = 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input combinational arbiter producing a one-hot grant.
// Config macro WB_ROUND_ROBIN_EN: defined -> round-robin on 'last',
// undefined -> fixed priority, req[0] always wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef WB_ROUND_ROBIN_EN
  // On contention grant the requester that did not win last time
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end
`else
  logic w_unused_last;
  assign w_unused_last = last;

  // Fixed priority: req[0] always wins contention
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (req0) and the load
// unit (req1). Registered output stage, one write per cycle, plus a
// scoreboard of registers with an issued-but-uncommitted write.
// Config macro WB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module regfile_wb_arbiter
  import rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            issue_set,
  input  logic [AW-1:0]   issue_addr,
  output logic            rf_we,
  output logic [AW-1:0]   rf_regw,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] busy,
  output logic            grant_last
);

  wb_req_t         w_req_alu;
  wb_req_t         w_req_ld;
  wb_req_t         w_sel;
  logic [1:0]      w_valids;
  logic [1:0]      w_gnt;
  logic            w_accept;
  logic [NREG-1:0] w_busy_nxt;

  logic            r_we;
  logic [AW-1:0]   r_regw;
  logic [DW-1:0]   r_wdata;
  logic [NREG-1:0] r_busy;
  logic            r_grant_last;

  assign w_req_alu = '{valid: req0_valid, addr: req0_addr, data: req0_data};
  assign w_req_ld  = '{valid: req1_valid, addr: req1_addr, data: req1_data};

  assign w_valids[REQ_ALU] = w_req_alu.valid;
  assign w_valids[REQ_LD]  = w_req_ld.valid;

  rr_arbiter2 u_arb (
    .req  (w_valids),
    .last (r_grant_last),
    .gnt  (w_gnt)
  );

  assign req0_ready = w_gnt[REQ_ALU];
  assign req1_ready = w_gnt[REQ_LD];
  assign w_accept   = |w_gnt;

  // Mux the granted request into the output stage
  always_comb begin
    w_sel = w_gnt[REQ_LD] ? w_req_ld : w_req_alu;
  end

  // Scoreboard update: commit clears first, then issue sets, so a new
  // producer issued in the commit cycle keeps the bit pending
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) w_busy_nxt[r_regw] = 1'b0;
    if (issue_set) w_busy_nxt[issue_addr] = 1'b1;
  end

  // Output register, grant history and scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_regw       <= '0;
      r_wdata      <= '0;
      r_busy       <= '0;
      r_grant_last <= 1'b1;
    end else begin
      r_we   <= w_accept;
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        r_regw       <= w_sel.addr;
        r_wdata      <= w_sel.data;
        r_grant_last <= w_gnt[REQ_LD];
      end
    end
  end

  assign rf_we      = r_we;
  assign rf_regw    = r_regw;
  assign rf_wdata   = r_wdata;
  assign busy       = r_busy;
  assign grant_last = r_grant_last;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [2:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [2:0]  req1_addr;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        issue_set;
  logic [2:0]  issue_addr;
  logic        rf_we;
  logic [2:0]  rf_regw;
  logic [15:0] rf_wdata;
  logic [7:0]  busy;
  logic        grant_last;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .issue_set  (issue_set),
    .issue_addr (issue_addr),
    .rf_we      (rf_we),
    .rf_regw    (rf_regw),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .grant_last (grant_last)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    issue_set  = 1'b0; issue_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 16'h5a5a;
    issue_set = 1'b1; issue_addr = 3'd2;
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", rf_we); end
    n_checks++;
    if (busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", busy); end
    n_checks++;
    if (grant_last !== 1'b1) begin n_fail++; $display("FAIL reset_grant_last: got %0b want 1", grant_last); end
    n_checks++;
    if (rf_regw !== 3'd0 || rf_wdata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_regw_wdata: got %0d/%h want 0/0000", rf_regw, rf_wdata);
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'h8001;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: got %0b%0b want r0=1 r1=0", req0_ready, req1_ready);
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_regw !== 3'd3 || rf_wdata !== 16'h8001) begin
      n_fail++; $display("FAIL single_out: got we=%0b regw=%0d wdata=%h want 1/3/8001", rf_we, rf_regw, rf_wdata);
    end
    n_checks++;
    if (grant_last !== 1'b0) begin n_fail++; $display("FAIL single_grant_last: got %0b want 0", grant_last); end
    #1;
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready: got %0b%0b want 00", req0_ready, req1_ready);
    end
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0 || rf_regw !== 3'd3 || rf_wdata !== 16'h8001) begin
      n_fail++; $display("FAIL single_hold: got we=%0b regw=%0d wdata=%h want 0/3/8001", rf_we, rf_regw, rf_wdata);
    end
    n_checks++;
    if (busy !== 8'h00) begin n_fail++; $display("FAIL single_busy: got %h want 00", busy); end
  endtask

  // Lone load-unit write to R0 with a negative value
  task automatic test_lone_req1_r0();
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 3'd0; req1_data = 16'hffff;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL r0_ready: got r0=%0b r1=%0b want 0/1", req0_ready, req1_ready);
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_regw !== 3'd0 || rf_wdata !== 16'hffff || grant_last !== 1'b1) begin
      n_fail++; $display("FAIL r0_out: got we=%0b regw=%0d wdata=%h gl=%0b want 1/0/ffff/1",
                         rf_we, rf_regw, rf_wdata, grant_last);
    end
  endtask

  task automatic test_contention();
    logic       exp_r1 [4];
    logic [2:0] exp_addr [4];
`ifdef WB_ROUND_ROBIN_EN
    exp_r1 = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_addr = '{3'd1, 3'd2, 3'd1, 3'd2};
`else
    exp_r1 = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_addr = '{3'd1, 3'd1, 3'd1, 3'd1};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (rf_we !== 1'b1 || rf_regw !== exp_addr[i-1]) begin
          n_fail++; $display("FAIL contend_regw[%0d]: got we=%0b regw=%0d want 1/%0d", i-1, rf_we, rf_regw, exp_addr[i-1]);
        end
      end
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h0101;
      req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h0202;
      #1;
      n_checks++;
      if (req1_ready !== exp_r1[i] || req0_ready !== ~exp_r1[i]) begin
        n_fail++; $display("FAIL contend_grant[%0d]: got r0=%0b r1=%0b want r1=%0b", i, req0_ready, req1_ready, exp_r1[i]);
      end
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_regw !== exp_addr[3] || grant_last !== exp_r1[3]) begin
      n_fail++; $display("FAIL contend_last: got we=%0b regw=%0d gl=%0b want 1/%0d/%0b",
                         rf_we, rf_regw, grant_last, exp_addr[3], exp_r1[3]);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    @(negedge clk);
    issue_set = 1'b1; issue_addr = 3'd5;
    @(negedge clk);
    issue_set = 1'b0;
    n_checks++;
    if (busy !== 8'h20) begin n_fail++; $display("FAIL sb_set: got %h want 20", busy); end
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'h1234;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready: got %0b want 1", req1_ready); end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_regw !== 3'd5 || busy !== 8'h20) begin
      n_fail++; $display("FAIL sb_commit: got we=%0b regw=%0d busy=%h want 1/5/20", rf_we, rf_regw, busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 8'h00) begin n_fail++; $display("FAIL sb_clear: got %h want 00", busy); end
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    issue_set = 1'b1; issue_addr = 3'd5;
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'h7fff;
    @(negedge clk);
    // rf_we=1 regw=5 this cycle while issuing R5 again
    req0_valid = 1'b0;
    n_checks++;
    if (rf_we !== 1'b1 || rf_regw !== 3'd5 || busy !== 8'h20) begin
      n_fail++; $display("FAIL coll_pre: got we=%0b regw=%0d busy=%h want 1/5/20", rf_we, rf_regw, busy);
    end
    @(negedge clk);
    issue_set = 1'b0;
    n_checks++;
    if (busy !== 8'h20) begin n_fail++; $display("FAIL coll_keep: got %h want 20", busy); end
    // Commit to R5 clears while issuing R6 sets, in the same cycle
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'h0001;
    @(negedge clk);
    req0_valid = 1'b0;
    issue_set = 1'b1; issue_addr = 3'd6;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (busy !== 8'h40) begin n_fail++; $display("FAIL coll_swap: got %h want 40", busy); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
      req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h2222;
      issue_set = 1'b1; issue_addr = 3'd7;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 8'h80 || rf_we !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got busy=%h we=%0b want 80/1", busy, rf_we);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue_set = 1'b0;
    n_checks++;
    if (rf_we !== 1'b0 || busy !== 8'h00 || grant_last !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got we=%0b busy=%h gl=%0b want 0/00/1", rf_we, busy, grant_last);
    end
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_first_grant: got r0=%0b r1=%0b want 1/0", req0_ready, req1_ready);
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_regw !== 3'd1 || rf_wdata !== 16'h1111) begin
      n_fail++; $display("FAIL mid_first_write: got we=%0b regw=%0d wdata=%h want 1/1/1111", rf_we, rf_regw, rf_wdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_write();
    test_lone_req1_r0();
    test_contention();
    test_scoreboard();
    test_collision();
    test_reset_midstream();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
